// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO register block (hilo_unit and hilo_half).
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MF_LO = 1'b0,
        MF_HI = 1'b1
    } mf_sel_t;

endpackage

// File: rtl/hilo_half.sv
// One architectural half (HI or LO): data register, MT-override flag and the
// write-priority mux (MT write beats the committed mul/div result).
module hilo_half
    import hilo_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         commit_i,
    input  logic [N-1:0] res_i,
    input  logic         mt_we_i,
    input  logic [N-1:0] mt_data_i,
    input  logic         ovr_set_i,
    input  logic         ovr_clr_i,
    output logic [N-1:0] val_o,
    output logic         ovr_o
);

    logic [N-1:0] val_q, val_d;
    logic         ovr_q, ovr_d;

    always_comb begin
        val_d = val_q;
        if (mt_we_i) begin
            val_d = mt_data_i;
        end else if (commit_i && !ovr_q) begin
            val_d = res_i;
        end
    end

    // Clearing wins: a commit, flush or new op ends the override window.
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end else if (ovr_set_i) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            val_q <= val_d;
            ovr_q <= ovr_d;
        end
    end

    assign val_o = val_q;
    assign ovr_o = ovr_q;

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO owner behind the mul/div unit: op tracking FSM, commit,
// MT writes and MF read stall. Define HILO_BYPASS_EN to forward MF read data.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         md_start,
    input  logic         md_write,
    input  logic [N-1:0] md_hi,
    input  logic [N-1:0] md_lo,
    input  logic         mt_hi_we,
    input  logic         mt_lo_we,
    input  logic [N-1:0] mt_data,
    input  logic         mf_req,
    input  logic         mf_sel_hi,
    input  logic         flush,
    input  logic         pipe_stall,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic [N-1:0] mf_data,
    output logic         mf_stall,
    output logic         md_clear,
    output logic         md_hold,
    output logic         busy
);

    state_t  state_q;
    mf_sel_t sel;
    logic    active, in_run, in_done;
    logic    commit, enter_run, ovr_clr;
    logic    ovr_hi, ovr_lo;
    logic    sel_ovr, mt_match, pending, commit_win;

    assign active     = (state_q != IDLE);
    assign in_run     = (state_q == RUN);
    assign in_done    = (state_q == DONE);
    assign commit_win = in_done && !pipe_stall;
    assign commit     = commit_win && !flush;
    assign enter_run  = md_start && !flush && ((state_q == IDLE) || commit_win);
    assign ovr_clr    = commit || flush || enter_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (md_start && !flush) state_q <= RUN;
                RUN: begin
                    if (flush)         state_q <= IDLE;
                    else if (md_write) state_q <= DONE;
                end
                DONE: begin
                    if (flush)            state_q <= IDLE;
                    else if (!pipe_stall) state_q <= md_start ? RUN : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    hilo_half #(.N(N)) u_hi (
        .clk_i     (clk),
        .rst_i     (reset),
        .commit_i  (commit),
        .res_i     (md_hi),
        .mt_we_i   (mt_hi_we),
        .mt_data_i (mt_data),
        .ovr_set_i (active && mt_hi_we),
        .ovr_clr_i (ovr_clr),
        .val_o     (hi),
        .ovr_o     (ovr_hi)
    );

    hilo_half #(.N(N)) u_lo (
        .clk_i     (clk),
        .rst_i     (reset),
        .commit_i  (commit),
        .res_i     (md_lo),
        .mt_we_i   (mt_lo_we),
        .mt_data_i (mt_data),
        .ovr_set_i (active && mt_lo_we),
        .ovr_clr_i (ovr_clr),
        .val_o     (lo),
        .ovr_o     (ovr_lo)
    );

    assign md_clear = (reset || flush) && active;
    assign md_hold  = in_done && pipe_stall;
    assign busy     = active;

    assign sel      = mf_sel_t'(mf_sel_hi);
    assign sel_ovr  = (sel == MF_HI) ? ovr_hi : ovr_lo;
    assign mt_match = (sel == MF_HI) ? mt_hi_we : mt_lo_we;
    assign pending  = in_run || (in_done && pipe_stall);

`ifdef HILO_BYPASS_EN
    assign mf_stall = mf_req && pending && !sel_ovr && !mt_match;

    always_comb begin
        mf_data = (sel == MF_HI) ? hi : lo;
        if (mt_match) begin
            mf_data = mt_data;
        end else if (commit_win && !sel_ovr) begin
            mf_data = (sel == MF_HI) ? md_hi : md_lo;
        end
    end
`else
    // Without forwarding the commit cycle and a same-cycle MT must retry.
    assign mf_stall = mf_req && ((((pending || commit_win) && !sel_ovr)) || mt_match);
    assign mf_data  = (sel == MF_HI) ? hi : lo;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: MF reads go through an expected-data queue.
module tb_hilo_unit;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         md_start = 1'b0, md_write = 1'b0;
    logic [N-1:0] md_hi = '0, md_lo = '0;
    logic         mt_hi_we = 1'b0, mt_lo_we = 1'b0;
    logic [N-1:0] mt_data = '0;
    logic         mf_req = 1'b0, mf_sel_hi = 1'b0;
    logic         flush = 1'b0, pipe_stall = 1'b0;
    logic [N-1:0] hi, lo, mf_data;
    logic         mf_stall, md_clear, md_hold, busy;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [N-1:0] exp_q[$];
    logic         stalled;

    always #5 clk = ~clk;

    hilo_unit #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .md_start   (md_start),
        .md_write   (md_write),
        .md_hi      (md_hi),
        .md_lo      (md_lo),
        .mt_hi_we   (mt_hi_we),
        .mt_lo_we   (mt_lo_we),
        .mt_data    (mt_data),
        .mf_req     (mf_req),
        .mf_sel_hi  (mf_sel_hi),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .hi         (hi),
        .lo         (lo),
        .mf_data    (mf_data),
        .mf_stall   (mf_stall),
        .md_clear   (md_clear),
        .md_hold    (md_hold),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge with mf_req held; returns with mf_req dropped.
    task automatic wait_read(input string tag);
        for (int i = 0; i < 50 && mf_stall; i++) @(negedge clk);
        check(tag, 32'(mf_stall), 32'd0);
        if (mf_stall && exp_q.size() != 0) void'(exp_q.pop_front());
        tick();
        mf_req = 1'b0;
    endtask

    // Scoreboard: every accepted MF read consumes one expected value.
    always @(negedge clk) begin
        if (!reset && mf_req && !mf_stall) begin
            check("mf_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("mf_data", mf_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle read
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mf_req = 1'b1; mf_sel_hi = 1'b1; exp_q.push_back(32'h0);
        @(negedge clk);
        check("rst_stall", 32'(mf_stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clear", 32'(md_clear), 32'd0);
        check("rst_hold", 32'(md_hold), 32'd0);
        wait_read("rst_read");

        // Long op, read stalled through RUN and the commit
        md_start = 1'b1;
        tick(); md_start = 1'b0;
        mf_req = 1'b1; mf_sel_hi = 1'b1; exp_q.push_back(32'h1);
        @(negedge clk);
        check("run_stall", 32'(mf_stall), 32'd1);
        check("run_busy", 32'(busy), 32'd1);
        repeat (33) tick();
        md_write = 1'b1; md_hi = 32'h1; md_lo = 32'hFFFF_FFFE;
        tick(); md_write = 1'b0;
        @(negedge clk);
        check("commit_hold", 32'(md_hold), 32'd0);
        wait_read("run_read");
        @(negedge clk);
        check("c1_hi", hi, 32'h1);
        check("c1_lo", lo, 32'hFFFF_FFFE);
        check("c1_busy", 32'(busy), 32'd0);

        // Held result while the pipeline is stalled
        tick(); md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick(); md_write = 1'b1; md_hi = 32'hA; md_lo = 32'hB;
        tick(); md_write = 1'b0; pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_on", 32'(md_hold), 32'd1);
            check("hold_hi", hi, 32'h1);
            check("hold_lo", lo, 32'hFFFF_FFFE);
            tick();
        end
        pipe_stall = 1'b0;
        @(negedge clk);
        check("hold_off", 32'(md_hold), 32'd0);
        tick();
        @(negedge clk);
        check("c2_hi", hi, 32'hA);
        check("c2_lo", lo, 32'hB);

        // MTHI during RUN overrides the HI half of the result
        tick(); md_start = 1'b1;
        tick(); md_start = 1'b0; mt_hi_we = 1'b1; mt_data = 32'hDEAD_BEEF;
        tick(); mt_hi_we = 1'b0;
        mf_req = 1'b1; mf_sel_hi = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("ovr_nostall", 32'(mf_stall), 32'd0);
        tick(); mf_req = 1'b0; md_write = 1'b1; md_hi = 32'h5; md_lo = 32'h7;
        tick(); md_write = 1'b0;
        tick();
        @(negedge clk);
        check("ovr_hi", hi, 32'hDEAD_BEEF);
        check("ovr_lo", lo, 32'h7);

        // Flush in RUN, late md_write ignored
        tick(); md_start = 1'b1;
        tick(); md_start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_clear", 32'(md_clear), 32'd1);
        tick(); flush = 1'b0; md_write = 1'b1; md_hi = 32'h99; md_lo = 32'h98;
        @(negedge clk);
        check("flush_clear_off", 32'(md_clear), 32'd0);
        check("flush_idle", 32'(busy), 32'd0);
        tick(); md_write = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hi", hi, 32'hDEAD_BEEF);
        check("flush_lo", lo, 32'h7);

        // MFLO in the commit cycle
        tick(); md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick(); md_write = 1'b1; md_hi = 32'h43; md_lo = 32'h42;
        tick(); md_write = 1'b0;
        mf_req = 1'b1; mf_sel_hi = 1'b0; exp_q.push_back(32'h42);
        @(negedge clk);
`ifdef HILO_BYPASS_EN
        check("cw_stall", 32'(mf_stall), 32'd0);
`else
        check("cw_stall", 32'(mf_stall), 32'd1);
`endif
        wait_read("cw_read");

        // MTHI coincident with an MFHI read in IDLE
        mt_hi_we = 1'b1; mt_data = 32'h55;
        mf_req = 1'b1; mf_sel_hi = 1'b1; exp_q.push_back(32'h55);
        @(negedge clk);
`ifdef HILO_BYPASS_EN
        check("mt_fwd_stall", 32'(mf_stall), 32'd0);
`else
        check("mt_fwd_stall", 32'(mf_stall), 32'd1);
`endif
        stalled = mf_stall;
        tick(); mt_hi_we = 1'b0;
        if (stalled) begin
            @(negedge clk);
            wait_read("mt_read");
        end else begin
            mf_req = 1'b0;
        end
        @(negedge clk);
        check("mt_hi", hi, 32'h55);

        // MTLO in the commit cycle wins over the result
        tick(); md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick(); md_write = 1'b1; md_hi = 32'h12; md_lo = 32'h11;
        tick(); md_write = 1'b0; mt_lo_we = 1'b1; mt_data = 32'h77;
        tick(); mt_lo_we = 1'b0;
        @(negedge clk);
        check("mtc_hi", hi, 32'h12);
        check("mtc_lo", lo, 32'h77);

        // Back-to-back op, then reset mid-operation
        tick(); md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick(); md_write = 1'b1; md_hi = 32'h21; md_lo = 32'h22;
        tick(); md_write = 1'b0; md_start = 1'b1;
        tick(); md_start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_hi", hi, 32'h21);
        check("b2b_lo", lo, 32'h22);
        tick(); reset = 1'b1;
        @(negedge clk);
        check("rst_mid_clear", 32'(md_clear), 32'd1);
        tick(); reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        check("rst_mid_clear_off", 32'(md_clear), 32'd0);

        check("mf_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
